// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample tick every N(+1) clocks, bit tick every OSR oversample ticks.
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
module uart_baud_gen_frac #(
  parameter int SIZE_BAUD   = 24,
  parameter int FRAC_W      = 4,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 325
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [SIZE_BAUD-1:0] i_div_int,
  input  logic [FRAC_W-1:0]    i_div_frac,
  input  logic                 i_div_load,
  input  logic                 i_resync,
  output logic                 o_os_tick,
  output logic                 o_bit_tick,
  output logic                 o_cfg_err
);

  localparam int                   OS_W    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]      OS_ONE  = OS_W'(1);
  localparam logic [SIZE_BAUD-1:0] DIV_RST = SIZE_BAUD'(DEFAULT_DIV);
  localparam logic [SIZE_BAUD-1:0] DIV_MIN = SIZE_BAUD'(2);
  localparam logic [SIZE_BAUD-1:0] CNT_ONE = SIZE_BAUD'(1);
  localparam logic [SIZE_BAUD:0]   ONE_X   = {{SIZE_BAUD{1'b0}}, 1'b1};

  logic [SIZE_BAUD-1:0] per_cnt_r;
  logic [SIZE_BAUD-1:0] div_act_r;
  logic [SIZE_BAUD-1:0] div_shd_r;
  logic [SIZE_BAUD-1:0] shd_int_s;
  logic [OS_W-1:0]      os_cnt_r;
  logic [OS_W-1:0]      os_cnt_nxt_s;
  logic [SIZE_BAUD:0]   term_s;
  logic                 os_tick_r;
  logic                 bit_tick_r;
  logic                 cfg_err_r;
  logic                 cfg_err_s;
  logic                 ext_s;
  logic                 wrap_s;
  logic                 os_last_s;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_shd_r;
  logic [FRAC_W-1:0] shd_frac_s;
  logic [FRAC_W-1:0] acc_r;
  logic              ext_r;
  logic [FRAC_W:0]   acc_sum_s;
  logic [FRAC_W:0]   acc_seed_s;

  assign ext_s = ext_r;

  // Fraction for the period about to start, and the accumulator step it causes
  always_comb begin
    shd_frac_s = frac_shd_r;
    if (i_div_load) begin
      shd_frac_s = i_div_frac;
    end else begin
      shd_frac_s = frac_shd_r;
    end
    acc_seed_s = {1'b0, shd_frac_s};
    acc_sum_s  = {1'b0, acc_r} + {1'b0, shd_frac_s};
  end
`else
  logic unused_frac_s;

  assign ext_s         = 1'b0;
  assign unused_frac_s = ^i_div_frac;
`endif

  // Shadow divisor as it will stand after this cycle; illegal divisors clamp to 2
  always_comb begin
    shd_int_s = div_shd_r;
    cfg_err_s = cfg_err_r;
    if (i_div_load) begin
      if (i_div_int < DIV_MIN) begin
        shd_int_s = DIV_MIN;
        cfg_err_s = 1'b1;
      end else begin
        shd_int_s = i_div_int;
        cfg_err_s = 1'b0;
      end
    end else begin
      shd_int_s = div_shd_r;
      cfg_err_s = cfg_err_r;
    end
  end

  // Terminal count compare one bit wider than the divisor, so N-1+E cannot overflow
  always_comb begin
    term_s    = {1'b0, div_act_r} - ONE_X + {{SIZE_BAUD{1'b0}}, ext_s};
    wrap_s    = ({1'b0, per_cnt_r} >= term_s);
    os_last_s = (os_cnt_r == OS_LAST);
    if (os_last_s) begin
      os_cnt_nxt_s = {OS_W{1'b0}};
    end else begin
      os_cnt_nxt_s = os_cnt_r + OS_ONE;
    end
  end

  // Counters, divisor hand-over from shadow to active, and registered ticks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      per_cnt_r  <= {SIZE_BAUD{1'b0}};
      os_cnt_r   <= {OS_W{1'b0}};
      div_act_r  <= DIV_RST;
      div_shd_r  <= DIV_RST;
      os_tick_r  <= 1'b0;
      bit_tick_r <= 1'b0;
      cfg_err_r  <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_shd_r <= {FRAC_W{1'b0}};
      acc_r      <= {FRAC_W{1'b0}};
      ext_r      <= 1'b0;
`endif
    end else begin
      div_shd_r  <= shd_int_s;
      cfg_err_r  <= cfg_err_s;
      os_tick_r  <= 1'b0;
      bit_tick_r <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_shd_r <= shd_frac_s;
`endif
      if (i_resync) begin
        per_cnt_r <= {SIZE_BAUD{1'b0}};
        os_cnt_r  <= {OS_W{1'b0}};
        div_act_r <= shd_int_s;
`ifdef BAUD_FRAC_EN
        // Cleared accumulator takes its start-of-period step straight away
        {ext_r, acc_r} <= acc_seed_s;
`endif
      end else if (i_en) begin
        if (wrap_s) begin
          per_cnt_r  <= {SIZE_BAUD{1'b0}};
          os_cnt_r   <= os_cnt_nxt_s;
          os_tick_r  <= 1'b1;
          bit_tick_r <= os_last_s;
          div_act_r  <= shd_int_s;
`ifdef BAUD_FRAC_EN
          {ext_r, acc_r} <= acc_sum_s;
`endif
        end else begin
          per_cnt_r <= per_cnt_r + CNT_ONE;
        end
      end else begin
        div_act_r <= shd_int_s;
      end
    end
  end

  assign o_os_tick  = os_tick_r;
  assign o_bit_tick = bit_tick_r;
  assign o_cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed self-checking bench for uart_baud_gen_frac (default parameters).
// Cycle k = k-th rising edge after the last reset edge; outputs sampled 1 ns after it.
module tb_uart_baud_gen_frac;

  localparam int SIZE_BAUD = 24;
  localparam int FRAC_W    = 4;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_en;
  logic [SIZE_BAUD-1:0] i_div_int;
  logic [FRAC_W-1:0]    i_div_frac;
  logic                 i_div_load;
  logic                 i_resync;
  logic                 o_os_tick;
  logic                 o_bit_tick;
  logic                 o_cfg_err;

  int cyc;
  int pass_cnt;
  int total_cnt;

  typedef struct {
    int   cyc;
    logic os;
    logic bt;
    logic err;
  } vec_t;

  vec_t vecs[10];

  uart_baud_gen_frac dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_div_load (i_div_load),
    .i_resync   (i_resync),
    .o_os_tick  (o_os_tick),
    .o_bit_tick (o_bit_tick),
    .o_cfg_err  (o_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt = total_cnt + 1;
    if (act == exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_en       = 1'b0;
    i_div_load = 1'b0;
    i_resync   = 1'b0;
    i_div_int  = '0;
    i_div_frac = '0;
    step();
    step();
    chk("rst_os_tick", int'(o_os_tick), 0);
    chk("rst_bit_tick", int'(o_bit_tick), 0);
    chk("rst_cfg_err", int'(o_cfg_err), 0);
    i_rst = 1'b0;
    i_en  = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_os_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_bit(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_bit_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic load_div(input int n, input int f);
    i_div_int  = SIZE_BAUD'(n);
    i_div_frac = FRAC_W'(f);
    i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    int exp;
    int seen;

    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;

    vecs[0] = '{cyc: 1,    os: 1'b0, bt: 1'b0, err: 1'b0};
    vecs[1] = '{cyc: 324,  os: 1'b0, bt: 1'b0, err: 1'b0};
    vecs[2] = '{cyc: 325,  os: 1'b1, bt: 1'b0, err: 1'b0};
    vecs[3] = '{cyc: 326,  os: 1'b0, bt: 1'b0, err: 1'b0};
    vecs[4] = '{cyc: 650,  os: 1'b1, bt: 1'b0, err: 1'b0};
    vecs[5] = '{cyc: 975,  os: 1'b1, bt: 1'b0, err: 1'b0};
    vecs[6] = '{cyc: 4875, os: 1'b1, bt: 1'b0, err: 1'b0};
    vecs[7] = '{cyc: 5199, os: 1'b0, bt: 1'b0, err: 1'b0};
    vecs[8] = '{cyc: 5200, os: 1'b1, bt: 1'b1, err: 1'b0};
    vecs[9] = '{cyc: 5201, os: 1'b0, bt: 1'b0, err: 1'b0};

    // Default divisor 325, OSR 16
    do_reset();
    for (int v = 0; v < 10; v++) begin
      while (cyc < vecs[v].cyc) step();
      chk($sformatf("dflt_os@%0d", vecs[v].cyc), int'(o_os_tick), int'(vecs[v].os));
      chk($sformatf("dflt_bit@%0d", vecs[v].cyc), int'(o_bit_tick), int'(vecs[v].bt));
      chk($sformatf("dflt_err@%0d", vecs[v].cyc), int'(o_cfg_err), int'(vecs[v].err));
    end

    // Load 10 mid-period: current period finishes at 325 untouched
    do_reset();
    while (cyc < 99) step();
    load_div(10, 0);
    wait_tick(400, at);
    chk("load_tick1", at, 325);
    wait_tick(50, at);
    chk("load_tick2", at, 335);
    wait_tick(50, at);
    chk("load_tick3", at, 345);

    // Load 10 + frac 8 together with resync at cycle 5
    do_reset();
    while (cyc < 4) step();
    i_resync = 1'b1;
    load_div(10, 8);
    i_resync = 1'b0;
    exp = 5;
    for (int k = 0; k < 16; k++) begin
      exp = exp + ((FRAC_ON && (k % 2 == 1)) ? 11 : 10);
      wait_tick(30, at);
      chk($sformatf("frac_tick%0d", k), at, exp);
    end

    // Resync at cycle 200 of default config
    do_reset();
    while (cyc < 199) step();
    i_resync = 1'b1;
    step();
    i_resync = 1'b0;
    wait_tick(400, at);
    chk("resync_tick", at, 525);
    wait_bit(6000, at);
    chk("resync_bit", at, 5400);

    // Illegal divisor clamps to 2, then a legal reload clears the error
    do_reset();
    while (cyc < 9) step();
    load_div(1, 0);
    chk("err_set", int'(o_cfg_err), 1);
    wait_tick(400, at);
    chk("clamp_tick1", at, 325);
    wait_tick(10, at);
    chk("clamp_tick2", at, 327);
    wait_tick(10, at);
    chk("clamp_tick3", at, 329);
    load_div(5, 0);
    chk("err_clr", int'(o_cfg_err), 0);
    wait_tick(10, at);
    chk("reload_tick1", at, 331);
    wait_tick(10, at);
    chk("reload_tick2", at, 336);
    wait_tick(10, at);
    chk("reload_tick3", at, 341);

    // Enable low for cycles 300..349, then reset mid-operation
    do_reset();
    while (cyc < 299) step();
    i_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (o_os_tick === 1'b1) seen = seen + 1;
    end
    chk("en_low_no_tick", seen, 0);
    i_en = 1'b1;
    wait_tick(100, at);
    chk("en_resume_tick", at, 375);
    load_div(1, 0);
    chk("pre_rst_err", int'(o_cfg_err), 1);
    wait_tick(400, at);
    chk("pre_rst_tick", at, 700);
    step();
    i_rst = 1'b1;
    step();
    chk("midrst_os", int'(o_os_tick), 0);
    chk("midrst_err", int'(o_cfg_err), 0);
    i_rst = 1'b0;
    cyc   = 0;
    wait_tick(400, at);
    chk("post_rst_tick", at, 325);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
